// File: rtl/clkdiv_tick_sched_pkg.sv
// clkdiv_tick_sched_pkg: shared mode constants, config FSM states and channel record
// Ports: none (package).
package clkdiv_tick_sched_pkg;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_BURST    = 1'b1;

    // Widest burst count a channel can hold; CNTW must not exceed this.
    localparam int REM_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } cfg_state_t;

    typedef struct packed {
        logic             en;
        logic             mode;
        logic [4:0]       tap;
        logic [REM_W-1:0] remaining;
    } chan_cfg_t;

    // Taps beyond the divider width select its top bit.
    function automatic logic [4:0] clamp_tap(input logic [4:0] tap, input int divw);
        return (int'(tap) >= divw) ? 5'(divw - 1) : tap;
    endfunction

endpackage

// File: rtl/clkdiv_tick_sched_tick_chan.sv
// clkdiv_tick_sched_tick_chan: one tick channel (tap mux, edge detect, burst counter)
// Ports: clk, rst (async active-low); div_in divider bus; load writes ld_* into this
//        channel; sync clears the edge history; tick/done/busy registered outputs.
module clkdiv_tick_sched_tick_chan
    import clkdiv_tick_sched_pkg::*;
#(
    parameter int DIVW = 32,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DIVW-1:0] div_in,
    input  logic            load,
    input  logic            sync,
    input  logic            ld_en,
    input  logic            ld_mode,
    input  logic [4:0]      ld_tap,
    input  logic [CNTW-1:0] ld_count,
    output logic            tick,
    output logic            done,
    output logic            busy
);

    chan_cfg_t cfg;
    logic      prev;
    logic      lvl;
    logic      fire;
    logic      empty;
    logic      last;

    always_comb begin
        lvl   = div_in[cfg.tap];
        // A load or sync on this cycle swallows any tick that was due.
        fire  = cfg.en & lvl & ~prev & ~load & ~sync;
        empty = (ld_mode == MODE_BURST) & (ld_count == '0);
        last  = (cfg.mode == MODE_BURST) & (cfg.remaining == REM_W'(1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg  <= '0;
            prev <= 1'b0;
            tick <= 1'b0;
            done <= 1'b0;
            busy <= 1'b0;
        end else begin
            busy <= cfg.en;
            tick <= fire;
            // An empty burst completes straight away; an overwritten burst never reports.
            done <= load ? (ld_en & empty) : (fire & last);
            if (load) begin
                cfg.en        <= ld_en & ~empty;
                cfg.mode      <= ld_mode;
                cfg.tap       <= ld_tap;
                cfg.remaining <= (ld_mode == MODE_BURST) ? REM_W'(ld_count) : '0;
                // Seed history with the new tap so an already-high tap is not an edge.
                prev          <= div_in[ld_tap];
            end else begin
                prev <= sync ? 1'b0 : lvl;
                if (fire && cfg.mode == MODE_BURST) begin
                    cfg.remaining <= cfg.remaining - REM_W'(1);
                    if (last) cfg.en <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/clkdiv_tick_sched.sv
// clkdiv_tick_sched: shares the divider bus among NCH tick channels with a config port
// Ports: clk, rst (async active-low); div_in divider bus; cfg_* valid/ready config
//        request (channel write or resync); div_clr divider clear pulse;
//        tick/busy/done per-channel outputs.
module clkdiv_tick_sched
    import clkdiv_tick_sched_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int DIVW = 32,
    parameter int CNTW = 8,
    parameter int CHW  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DIVW-1:0] div_in,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [CHW-1:0]  cfg_ch,
    input  logic [4:0]      cfg_tap,
    input  logic            cfg_mode,
    input  logic [CNTW-1:0] cfg_count,
    input  logic            cfg_en,
    input  logic            cfg_sync,
    output logic            div_clr,
    output logic [NCH-1:0]  tick,
    output logic [NCH-1:0]  busy,
    output logic [NCH-1:0]  done
);

    cfg_state_t      state;
    cfg_state_t      state_nx;
    logic            rdy;
    logic            hs;
    logic            apply;
    logic [CHW-1:0]  ch_q;
    logic [4:0]      tap_q;
    logic            mode_q;
    logic            en_q;
    logic            sync_q;
    logic [CNTW-1:0] count_q;

    // rdy holds cfg_ready low until the first clock after reset release.
    always_comb begin
        cfg_ready = rdy & (state == IDLE);
        hs        = cfg_valid & cfg_ready;
        apply     = state == APPLY;
        state_nx  = hs ? APPLY : IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            rdy     <= 1'b0;
            div_clr <= 1'b0;
            ch_q    <= '0;
            tap_q   <= '0;
            mode_q  <= MODE_PERIODIC;
            en_q    <= 1'b0;
            sync_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state   <= state_nx;
            rdy     <= 1'b1;
            div_clr <= hs & cfg_sync;
            if (hs) begin
                ch_q    <= cfg_ch;
                tap_q   <= clamp_tap(cfg_tap, DIVW);
                mode_q  <= cfg_mode;
                en_q    <= cfg_en;
                sync_q  <= cfg_sync;
                count_q <= cfg_count;
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        clkdiv_tick_sched_tick_chan #(
            .DIVW(DIVW),
            .CNTW(CNTW)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .div_in   (div_in),
            .load     (apply & ~sync_q & (ch_q == CHW'(g))),
            .sync     (apply & sync_q),
            .ld_en    (en_q),
            .ld_mode  (mode_q),
            .ld_tap   (tap_q),
            .ld_count (count_q),
            .tick     (tick[g]),
            .done     (done[g]),
            .busy     (busy[g])
        );
    end

endmodule

// File: doc/clkdiv_tick_sched.md
Name: clkdiv_tick_sched

Overview:
- Shares the free-running 32-bit divider bus among NCH requesters.
- Each channel selects one divider tap and gets single-cycle tick enables on that tap's rising edges, either periodic or as a counted burst.
- A valid/ready config port programs the channels and can also issue a resync that clears the shared divider.
- Sits between the divider and consumers such as the display scanner, debouncers and the register-file stepper.

Parameters:
- NCH, 4, number of tick channels (2..8)
- DIVW, 32, width of the divider bus
- CNTW, 8, width of the burst counter
- CHW, 2, channel index width (clog2 of NCH)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- div_in  in  DIVW  free-running divider value
- cfg_valid  in  1  config request
- cfg_ready  out  1  config can be accepted this cycle
- cfg_ch  in  CHW  target channel
- cfg_tap  in  5  tap index into div_in
- cfg_mode  in  1  0 = periodic, 1 = burst
- cfg_count  in  CNTW  burst length (ignored in periodic mode)
- cfg_en  in  1  channel enable
- cfg_sync  in  1  resync command; all other cfg fields are ignored
- div_clr  out  1  registered one-cycle clear pulse to the divider
- tick  out  NCH  per-channel one-cycle tick
- busy  out  NCH  channel enabled and running
- done  out  NCH  one-cycle pulse when a burst completes

Behaviour:
- Reset (rst low, async): all outputs 0 except cfg_ready; cfg_ready = 1 on the first clock after release. All channel registers are cleared (en = 0, tap = 0, mode = 0, remaining = 0, prev = 0).
- Config FSM states: IDLE and APPLY.
  - IDLE: cfg_ready = 1. A handshake (cfg_valid & cfg_ready) captures all cfg_* fields and moves to APPLY.
  - APPLY: lasts one cycle, cfg_ready = 0, then returns to IDLE. Maximum throughput is one config every 2 cycles.
  - cfg_valid held without ready: fields must stay stable; nothing is captured.
- APPLY, channel write (cfg_sync = 0):
  - Write tap/mode/en to channel cfg_ch and set prev[cfg_ch] = div_in[tap].
  - Setting prev this way means a tap that is already high does not produce a spurious tick.
  - Burst: remaining = cfg_count.
  - Burst with cfg_count = 0: en is forced to 0, no ticks are produced, and done[ch] pulses on the cycle after APPLY.
  - Writing a running channel aborts its current activity silently; no done is produced for the aborted burst.
  - cfg_tap >= DIVW is clamped to DIVW-1.
- APPLY, sync (cfg_sync = 1):
  - div_clr = 1 for exactly the APPLY cycle; all prev bits = 0; channel configuration is unchanged.
  - div_in is 0 from the following cycle, so no tick fires during the clear.
- Tick generation, per channel i, every cycle outside APPLY-to-i:
  - rise = div_in[tap_i] & ~prev_i
  - prev_i <= div_in[tap_i]
  - tick_i <= en_i & rise (registered)
  - Latency: tap rises on cycle t, tick is high on t+1.
  - Periodic period is 2^(tap+1) clk cycles. tap 0 gives a tick every 2 cycles.
- Burst mode:
  - Each tick decrements remaining.
  - The tick issued when remaining == 1 also asserts done_i in the same cycle, clears en_i, and leaves remaining = 0.
- busy_i = en_i, registered.
- Simultaneous events:
  - An APPLY to channel i overrides a tick due on i in that cycle; that tick is dropped.
  - Other channels tick normally during APPLY.
  - A sync APPLY suppresses all ticks in its cycle.
- Mid-operation reset: asynchronous clear; any pending burst is lost and no done is issued.

Decomposition:
- Shared package holds:
  - constants MODE_PERIODIC = 0 and MODE_BURST = 1
  - cfg FSM state encoding: IDLE and APPLY
  - a channel config record type: en, mode, tap, remaining
- One sub-module, tick_chan, is instantiated NCH times. It contains:
  - tap mux
  - edge detect
  - burst counter
  - tick/done/busy registers
  - load/sync inputs
- Top level holds the config FSM, the decode of cfg_ch, and div_clr.

Test Plan:
- Periodic: reset, config ch0 tap = 2, periodic, en = 1, counting div_in -> tick[0] exactly every 8 cycles, 1 cycle after div_in[2] rises; busy[0] = 1.
- Burst: ch1 tap = 0, burst, count = 3 -> exactly 3 ticks, 2 cycles apart; done[1] coincides with the 3rd tick; busy[1] drops the next cycle.
- Burst with count = 0: ch2 -> no ticks, done[2] one cycle after APPLY, busy[2] = 0.
- Handshake: hold cfg_valid for 4 back-to-back writes -> cfg_ready toggles 1,0,1,0, accepting one write per 2 cycles; every channel is configured correctly.
- Sync: all 4 channels running, issue cfg_sync -> div_clr high for 1 cycle, no tick in the clear cycle or the next, then periodic spacing resumes from div_in = 0.
- Abort and reset:
  - Rewrite ch1 mid-burst -> no done[1].
  - Assert rst low mid-burst between clocks -> all outputs 0 immediately, cfg_ready = 1 on the first clock after release.
